// File: rtl/conv_pkg.sv
// Shared constants, types and helpers for the convolution unit and its result writer.
package conv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [2:0] F3_SETBASE  = 3'b000;
    localparam logic [2:0] F3_SETSIZE  = 3'b001;
    localparam logic [2:0] F3_RUN      = 3'b010;
    localparam logic [2:0] F3_SETOUT   = 3'b011;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ISSUE,
        WR_WAIT_ACK,
        WR_DONE
    } wr_state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } lsu_store_t;

    // Word address of result idx; wraps modulo 2^32 by construction.
    function automatic logic [XLEN-1:0] store_addr(input logic [XLEN-1:0] base,
                                                   input logic [XLEN-1:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/conv_result_fifo.sv
// Synchronous result FIFO with a look-ahead read port for back-to-back draining.
module conv_result_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_c,
    output logic [WIDTH-1:0]         next_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_next_c;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_c, do_pop_c;

    assign full_c    = (count_q == CW'(DEPTH));
    assign empty_c   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_next_c = rd_ptr_q + AW'(1);
    assign head_c    = mem_q[rd_ptr_q];
    assign next_c    = mem_q[rd_next_c];

    always_comb begin
        do_push_c = push_i && !full_c;
        do_pop_c  = pop_i && !empty_c;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop_c)  rd_ptr_d = rd_next_c;
            count_d = count_q + CW'(do_push_c) - CW'(do_pop_c);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (do_push_c && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/conv_result_writer.sv
// Buffers convolution results and drains them to memory as consecutive word stores.
module conv_result_writer
    import conv_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MAX_OUT    = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic        opcode_invalid_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
    input  logic        res_valid_i,
    input  logic [31:0] res_data_i,
    output logic        lsu_wr_o,
    output logic [31:0] lsu_addr_o,
    output logic [31:0] lsu_data_o,
    input  logic        lsu_req_ready_i,
    input  logic        lsu_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        overflow_o
);
    localparam int unsigned IDX_W = $clog2(MAX_OUT);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    wr_state_e        state_q, state_d;
    logic             armed_q, armed_d;
    logic [31:0]      out_base_q, out_base_d;
    logic [IDX_W-1:0] out_count_q, out_count_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] acc_cnt_q, acc_cnt_d;
    lsu_store_t       store_q, store_d;
    logic             lsu_wr_q, lsu_wr_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;

    logic             setout_c, push_c, pop_c;
    logic [IDX_W-1:0] wr_idx_inc_c;
    logic [31:0]      next_data_c;
    logic [31:0]      fifo_head_c, fifo_next_c;
    logic             fifo_full_c, fifo_empty_c;
    logic [CNT_W-1:0] fifo_count;
    logic             unused_c;

    assign unused_c = ^{opcode_opcode_i[31:15], opcode_opcode_i[11:7],
                        opcode_rb_operand_i[31:IDX_W]};

    conv_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (setout_c),
        .push_i  (push_c),
        .data_i  (res_data_i),
        .pop_i   (pop_c),
        .head_c  (fifo_head_c),
        .next_c  (fifo_next_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        out_base_d  = out_base_q;
        out_count_d = out_count_q;
        wr_idx_d    = wr_idx_q;
        acc_cnt_d   = acc_cnt_q;
        store_d     = store_q;
        lsu_wr_d    = lsu_wr_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        pop_c       = 1'b0;

        setout_c = opcode_valid_i && !opcode_invalid_i && !armed_q
                   && (opcode_opcode_i[6:0] == OPC_CUSTOM0)
                   && (opcode_opcode_i[14:12] == F3_SETOUT);
        push_c   = res_valid_i && armed_q && !fifo_full_c && (acc_cnt_q < out_count_q);
        wr_idx_inc_c = wr_idx_q + IDX_W'(1);
        // A result pushed while only one entry remains becomes the next head directly.
        next_data_c  = (fifo_count > CNT_W'(1)) ? fifo_next_c : res_data_i;

        if (setout_c) begin
            out_base_d  = opcode_ra_operand_i;
            out_count_d = opcode_rb_operand_i[IDX_W-1:0];
            wr_idx_d    = '0;
            acc_cnt_d   = '0;
            overflow_d  = 1'b0;
            armed_d     = (opcode_rb_operand_i[IDX_W-1:0] != '0);
        end else begin
            if (push_c) acc_cnt_d = acc_cnt_q + IDX_W'(1);
            if (res_valid_i && armed_q && !push_c) overflow_d = 1'b1;
        end

        case (state_q)
            WR_IDLE: begin
                if (armed_q && !fifo_empty_c) begin
                    state_d       = WR_ISSUE;
                    lsu_wr_d      = 1'b1;
                    store_d.addr  = store_addr(out_base_q, 32'(wr_idx_q));
                    store_d.data  = fifo_head_c;
                end
            end
            WR_ISSUE: begin
                if (lsu_req_ready_i) begin
                    state_d  = WR_WAIT_ACK;
                    lsu_wr_d = 1'b0;
                end
            end
            WR_WAIT_ACK: begin
                if (lsu_ack_i) begin
                    pop_c    = 1'b1;
                    wr_idx_d = wr_idx_inc_c;
                    if (wr_idx_inc_c == out_count_q) begin
                        state_d = WR_DONE;
                        done_d  = 1'b1;
                    end else if ((fifo_count > CNT_W'(1)) || push_c) begin
                        state_d      = WR_ISSUE;
                        lsu_wr_d     = 1'b1;
                        store_d.addr = store_addr(out_base_q, 32'(wr_idx_inc_c));
                        store_d.data = next_data_c;
                    end else begin
                        state_d = WR_IDLE;
                    end
                end
            end
            WR_DONE: begin
                state_d = WR_IDLE;
                armed_d = 1'b0;
            end
            default: state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= WR_IDLE;
            armed_q     <= 1'b0;
            out_base_q  <= '0;
            out_count_q <= '0;
            wr_idx_q    <= '0;
            acc_cnt_q   <= '0;
            store_q     <= '0;
            lsu_wr_q    <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            out_base_q  <= out_base_d;
            out_count_q <= out_count_d;
            wr_idx_q    <= wr_idx_d;
            acc_cnt_q   <= acc_cnt_d;
            store_q     <= store_d;
            lsu_wr_q    <= lsu_wr_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign lsu_wr_o   = lsu_wr_q;
    assign lsu_addr_o = store_q.addr;
    assign lsu_data_o = store_q.data;
    assign busy_o     = armed_q;
    assign done_o     = done_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_conv_result_writer.sv
// Scoreboard bench for conv_result_writer: directed and random runs against a queue-based model.
module tb_conv_result_writer;
    import conv_pkg::*;

    localparam int unsigned DEPTH = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        opcode_valid_i, opcode_invalid_i;
    logic [31:0] opcode_opcode_i, opcode_ra_operand_i, opcode_rb_operand_i;
    logic        res_valid_i;
    logic [31:0] res_data_i;
    logic        lsu_wr_o;
    logic [31:0] lsu_addr_o, lsu_data_o;
    logic        lsu_req_ready_i, lsu_ack_i;
    logic        busy_o, done_o, overflow_o;

    always #5 clk_i = ~clk_i;

    conv_result_writer #(.FIFO_DEPTH(DEPTH), .MAX_OUT(4096)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .opcode_valid_i      (opcode_valid_i),
        .opcode_opcode_i     (opcode_opcode_i),
        .opcode_invalid_i    (opcode_invalid_i),
        .opcode_ra_operand_i (opcode_ra_operand_i),
        .opcode_rb_operand_i (opcode_rb_operand_i),
        .res_valid_i         (res_valid_i),
        .res_data_i          (res_data_i),
        .lsu_wr_o            (lsu_wr_o),
        .lsu_addr_o          (lsu_addr_o),
        .lsu_data_o          (lsu_data_o),
        .lsu_req_ready_i     (lsu_req_ready_i),
        .lsu_ack_i           (lsu_ack_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .overflow_o          (overflow_o)
    );

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    bit          m_armed = 1'b0;
    bit          m_ovf = 1'b0;
    logic [31:0] m_base = '0;
    int          m_count = 0, m_acc = 0, m_acked = 0;
    int          exp_done = 0, done_seen = 0;
    int          ready_mode = 1;
    bit          ack_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_wr"},   32'(lsu_wr_o), 0);
        check({name, "_addr"}, lsu_addr_o, 0);
        check({name, "_data"}, lsu_data_o, 0);
        check({name, "_busy"}, 32'(busy_o), 0);
        check({name, "_done"}, 32'(done_o), 0);
        check({name, "_ovf"},  32'(overflow_o), 0);
    endtask

    // LSU request-ready driver: 0 = stalled, 1 = always ready, 2 = random.
    initial begin
        lsu_req_ready_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            case (ready_mode)
                0:       lsu_req_ready_i = 1'b0;
                1:       lsu_req_ready_i = 1'b1;
                default: lsu_req_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // LSU responder: acks each accepted store one cycle later; tracks pops and run completion.
    initial begin
        lsu_ack_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (ack_en && !rst_i && lsu_wr_o && lsu_req_ready_i) begin
                @(posedge clk_i); #1 lsu_ack_i = 1'b1;
                @(posedge clk_i);
                m_acked++;
                #1 lsu_ack_i = 1'b0;
                if (m_armed && m_acked == m_count) begin
                    exp_done++;
                    @(posedge clk_i);
                    m_armed = 1'b0;
                end
            end
        end
    end

    // Monitor: compares accepted stores against the scoreboard and checks request stability.
    initial begin
        bit          prev_hold;
        bit          prev_done;
        logic [31:0] prev_addr, prev_data;
        exp_t        e;
        prev_hold = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_hold = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_wr",   32'(lsu_wr_o), 1);
                    check("hold_addr", lsu_addr_o, prev_addr);
                    check("hold_data", lsu_data_o, prev_data);
                end
                prev_hold = lsu_wr_o && !lsu_req_ready_i;
                prev_addr = lsu_addr_o;
                prev_data = lsu_data_o;
                if (lsu_wr_o && lsu_req_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_store actual addr=0x%08h data=0x%08h required=no store",
                                 lsu_addr_o, lsu_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("store_addr", lsu_addr_o, e.addr);
                        check("store_data", lsu_data_o, e.data);
                    end
                end
                if (prev_done) check("done_one_cycle", 32'(done_o), 0);
                if (done_o) begin
                    done_seen++;
                    check("done_count", done_seen, exp_done);
                    check("done_pending", exp_q.size(), 0);
                end
                prev_done = done_o;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic issue(input bit valid, input bit invalid, input logic [6:0] opc,
                         input logic [2:0] f3, input logic [31:0] ra, input logic [31:0] rb);
        logic [31:0] instr;
        instr = $urandom();
        instr[6:0]   = opc;
        instr[14:12] = f3;
        opcode_valid_i      = valid;
        opcode_invalid_i    = invalid;
        opcode_opcode_i     = instr;
        opcode_ra_operand_i = ra;
        opcode_rb_operand_i = rb;
        if (valid && !invalid && opc == OPC_CUSTOM0 && f3 == F3_SETOUT && !m_armed) begin
            m_base  = ra;
            m_count = int'(rb[11:0]);
            m_acc   = 0;
            m_acked = 0;
            m_ovf   = 1'b0;
            m_armed = (m_count != 0);
        end
        @(posedge clk_i); #1;
        opcode_valid_i   = 1'b0;
        opcode_invalid_i = 1'b0;
    endtask

    task automatic setout(input logic [31:0] base, input logic [31:0] rb);
        issue(1'b1, 1'b0, OPC_CUSTOM0, F3_SETOUT, base, rb);
        check("setout_busy", 32'(busy_o), 32'(m_armed));
    endtask

    task automatic push(input logic [31:0] d);
        res_valid_i = 1'b1;
        res_data_i  = d;
        if (m_armed) begin
            if (m_acc < m_count && (m_acc - m_acked) < int'(DEPTH)) begin
                exp_q.push_back('{addr: m_base + 32'(m_acc) * 32'd4, data: d});
                m_acc++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        @(posedge clk_i); #1;
        res_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((m_armed || busy_o) && n < 1000) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({name, "_in_time"}, 32'(n < 1000), 1);
        check({name, "_busy"},    32'(busy_o), 0);
        check({name, "_ovf"},     32'(overflow_o), 32'(m_ovf));
        check({name, "_done"},    done_seen, exp_done);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        rst_i = 1'b1;
        opcode_valid_i = 1'b0; opcode_invalid_i = 1'b0; opcode_opcode_i = '0;
        opcode_ra_operand_i = '0; opcode_rb_operand_i = '0;
        res_valid_i = 1'b0; res_data_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_zero("reset");
        rst_i = 1'b0;
        idle(2);
        check_zero("post_reset");

        // Non-SETOUT or rejected instructions leave the writer idle.
        issue(1'b1, 1'b1, OPC_CUSTOM0, F3_SETOUT, 32'h1000, 32'd3);
        check("ign_invalid_busy", 32'(busy_o), 0);
        issue(1'b1, 1'b0, OPC_CUSTOM0, F3_RUN, 32'h1000, 32'd3);
        check("ign_funct3_busy", 32'(busy_o), 0);
        issue(1'b1, 1'b0, 7'b0101011, F3_SETOUT, 32'h1000, 32'd3);
        check("ign_opcode_busy", 32'(busy_o), 0);
        issue(1'b0, 1'b0, OPC_CUSTOM0, F3_SETOUT, 32'h1000, 32'd3);
        check("ign_novalid_busy", 32'(busy_o), 0);

        // Basic run, results spaced apart.
        ready_mode = 1;
        setout(32'h0000_1000, 32'd3);
        push(32'h11); idle(10);
        push(32'h22); idle(10);
        push(32'h33);
        wait_idle("basic");

        // Backpressure: LSU stalled while five results arrive.
        ready_mode = 0;
        idle(1);
        setout(32'h0000_2000, 32'd5);
        for (int i = 0; i < 5; i++) push($urandom());
        idle(15);
        ready_mode = 1;
        wait_idle("backpressure");

        // Overflow: ninth push into a full FIFO is dropped.
        ready_mode = 0;
        idle(1);
        setout(32'h0000_3000, 32'd9);
        for (int i = 0; i < 9; i++) push(32'hA000_0000 + 32'(i));
        check("overflow_set", 32'(overflow_o), 32'(m_ovf));
        ready_mode = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin idle(1); n++; end
        check("overflow_drain_in_time", 32'(n < 200), 1);
        idle(5);
        check("overflow_still_busy", 32'(busy_o), 32'(m_armed));
        push(32'h99);
        wait_idle("overflow");

        // Excess results and a SETOUT issued mid-run.
        setout(32'h0000_4000, 32'd2);
        push(32'hE1); push(32'hE2); push(32'hE3);
        setout(32'h0000_5000, 32'd7);
        wait_idle("excess");

        // Zero count never arms.
        setout(32'h0000_6000, 32'h0000_5000);
        push(32'h1); push(32'h2);
        idle(10);
        check("count0_wr",   32'(lsu_wr_o), 0);
        check("count0_busy", 32'(busy_o), 0);
        check("count0_ovf",  32'(overflow_o), 0);

        // Address wrap-around.
        setout(32'hFFFF_FFFC, 32'd2);
        push(32'hC0); push(32'hC1);
        wait_idle("wrap");

        // Asynchronous reset while waiting for the store ack.
        ack_en = 1'b0;
        setout(32'h0000_7000, 32'd2);
        push(32'hAA);
        n = 0;
        while (!(lsu_wr_o && lsu_req_ready_i) && n < 50) begin @(negedge clk_i); n++; end
        check("rst_handshake_seen", 32'(n < 50), 1);
        @(posedge clk_i); #3;
        check("rst_wait_ack_wr", 32'(lsu_wr_o), 0);
        rst_i = 1'b1;
        #1;
        check_zero("rst_mid");
        m_armed = 1'b0; m_ovf = 1'b0; exp_q.delete();
        @(posedge clk_i); #1;
        rst_i  = 1'b0;
        ack_en = 1'b1;
        setout(32'h0000_7100, 32'd2);
        push(32'hB0); push(32'hB1);
        wait_idle("after_rst");

        // Randomized runs with random LSU readiness and result spacing.
        ready_mode = 2;
        for (int r = 0; r < 20; r++) begin
            int cnt;
            cnt = $urandom_range(1, 8);
            setout($urandom(), ($urandom() & 32'hFFFF_F000) | 32'(cnt));
            for (int i = 0; i < cnt; i++) begin
                push($urandom());
                idle($urandom_range(0, 3));
            end
            wait_idle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_result_writer.md
# conv_result_writer

Downstream stage of the convolution unit. Accepts each 32-bit result pulse from the convolution unit's `valid_o`/`writeback_o` outputs and buffers it in a small FIFO. Drains the buffered results to data memory as word stores through the LSU store handshake, at consecutive addresses starting from a programmed output base. It is configured by its own custom-0 instruction. It reports completion once the programmed number of results has been stored.

## Interface
Parameters:
- FIFO_DEPTH, 8, result buffer entries (power of two, ≥2)
- MAX_OUT, 4096, maximum results per run (sets index width, 12 bits at default)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- opcode_valid_i  in  1  decoded instruction valid
- opcode_opcode_i  in  32  instruction word
- opcode_invalid_i  in  1  instruction invalid
- opcode_ra_operand_i  in  32  rs1 value: output base address
- opcode_rb_operand_i  in  32  rs2 value: result count, bits [11:0]
- res_valid_i  in  1  result strobe from the convolution unit (single-cycle pulse)
- res_data_i  in  32  result word
- lsu_wr_o  out  1  store request
- lsu_addr_o  out  32  store address
- lsu_data_o  out  32  store data
- lsu_req_ready_i  in  1  LSU accepts request
- lsu_ack_i  in  1  store completed
- busy_o  out  1  run armed and not yet complete
- done_o  out  1  one-cycle pulse when the last result is stored
- overflow_o  out  1  sticky flag: a result was dropped

## Operation
- Decode: the instruction is accepted when opcode_valid_i is 1, opcode_invalid_i is 0, opcode[6:0] is 7'b0001011, and funct3 is 3'b011 (SETOUT).
- SETOUT while idle:
  - Latches out_base = ra and out_count = rb[11:0].
  - Clears wr_idx, the FIFO, and overflow_o.
  - Sets armed = (out_count != 0).
- SETOUT while busy_o = 1 is ignored.
- Push: on res_valid_i, when armed, FIFO not full, and accepted count < out_count, the result is written into the FIFO.
  - Otherwise the result is dropped and overflow_o is set (it stays set until the next SETOUT or reset).
  - A result arriving while not armed is dropped silently.
- Addressing: lsu_addr_o = out_base + (wr_idx << 2), mod 2^32. Wrap-around is allowed and not flagged.
- FSM states and transitions:
  - IDLE: go to ISSUE when armed and the FIFO is non-empty.
  - ISSUE: lsu_wr_o = 1 with address and data held stable. Go to WAIT_ACK on the cycle lsu_req_ready_i = 1.
  - WAIT_ACK: lsu_wr_o = 0. On lsu_ack_i: pop the FIFO and increment wr_idx.
    - If wr_idx + 1 == out_count, go to DONE.
    - Else if the FIFO still holds an entry after the pop, go to ISSUE.
    - Else go to IDLE.
  - DONE: done_o = 1 for one cycle, armed cleared, go to IDLE.
- lsu_ack_i is ignored outside WAIT_ACK.
- lsu_data_o is the FIFO head, registered in the cycle ISSUE is entered.

## Timing
- Reset values: lsu_wr_o=0, lsu_addr_o=0, lsu_data_o=0, busy_o=0, done_o=0, overflow_o=0. State IDLE, FIFO empty, armed=0, out_base=0, out_count=0.
- Reset mid-store: the outstanding request is abandoned and the FIFO contents are lost.
- Push latency: a result pushed at edge N can raise lsu_wr_o at the earliest after edge N+1 (the IDLE→ISSUE decision is taken from registered FIFO status).
- Best-case store throughput: with lsu_req_ready_i=1 and lsu_ack_i returned one cycle later, one store per 2 cycles.
- Simultaneous push and pop in the same cycle are both performed. A push into a full FIFO is dropped even if a pop occurs in that cycle (full is evaluated from registered count).
- busy_o = armed. It falls in the cycle after done_o.
- The convolution unit produces at most one result per ~3·K² cycles, so FIFO_DEPTH=8 is not overrun by a stalled LSU of under ~24·K² cycles.

## Structure
- Shared package conv_pkg:
  - OPC_CUSTOM0
  - funct3 constants F3_SETBASE, F3_SETSIZE, F3_RUN, F3_SETOUT (3'b011)
  - writer state enum
- Sub-module conv_result_fifo: synchronous FIFO (DEPTH, WIDTH) with push, pop, head data, full and empty flags, registered count.

## Test plan
- Basic run: SETOUT base=0x1000, count=3; push 0x11, 0x22, 0x33 spaced 10 cycles apart; LSU always ready, ack 1 cycle later → stores 0x11@0x1000, 0x22@0x1004, 0x33@0x1008, then one done_o pulse and busy_o=0.
- Backpressure: lsu_req_ready_i held 0 for 20 cycles while 5 results are pushed (count=5) → lsu_wr_o, address and data stable throughout; all 5 stored in order; overflow_o=0.
- Overflow: FIFO_DEPTH=8, LSU stalled, 9 pushes → 9th result dropped, overflow_o=1; the first 8 are stored correctly once the LSU resumes.
- Excess results: count=2, 3 pushes → exactly 2 stores, done_o pulses, overflow_o=1; SETOUT issued during the run is ignored (base unchanged).
- Edge cases: SETOUT count=0 → busy_o stays 0 and pushes produce no store. Base 0xFFFFFFFC with count=2 → second address is 0x00000000.
- Async reset asserted in WAIT_ACK → all outputs return to 0 immediately; a subsequent SETOUT plus pushes runs normally.
